// File: rtl/mac_tile_scheduler.sv
// Tile sequencer for a MAC array computing y = W*x: walks row/column blocks of W,
// handshakes each operand tile, feeds partial sums back and keeps y in a readable buffer.
module mac_tile_scheduler #(
    parameter int DATA_WIDTH   = 16,
    parameter int ACC_WIDTH    = 32,
    parameter int FRAC_BITS    = 8,
    parameter int TILE_SIZE    = 16,
    parameter int OUT_SIZE     = 40,
    parameter int D_INNER      = 256,
    parameter int WAIT_TIMEOUT = 1024,
    localparam int N_ROWBLK    = (OUT_SIZE + TILE_SIZE - 1) / TILE_SIZE,
    localparam int N_COLBLK    = D_INNER / TILE_SIZE,
    localparam int RB_W        = (N_ROWBLK > 1) ? $clog2(N_ROWBLK) : 1,
    localparam int CB_W        = (N_COLBLK > 1) ? $clog2(N_COLBLK) : 1,
    localparam int ADDR_W      = (OUT_SIZE > 1) ? $clog2(OUT_SIZE) : 1
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            start,
    output logic                            busy,
    output logic                            done,
    output logic                            err,
    output logic                            tile_req,
    input  logic                            tile_rdy,
    output logic [RB_W-1:0]                 rb_idx,
    output logic [CB_W-1:0]                 cb_idx,
    output logic [2:0]                      arr_mode,
    output logic                            arr_valid_in,
    output logic                            arr_accumulate_en,
    output logic [TILE_SIZE*ACC_WIDTH-1:0]  arr_acc_in_vec,
    input  logic                            arr_done_tile,
    input  logic [TILE_SIZE*DATA_WIDTH-1:0] arr_result_vec,
    input  logic [ADDR_W-1:0]               y_rd_addr,
    output logic [DATA_WIDTH-1:0]           y_rd_data
);

    localparam int CNT_MAX = (WAIT_TIMEOUT > TILE_SIZE) ? WAIT_TIMEOUT : TILE_SIZE;
    localparam int CNT_W   = $clog2(CNT_MAX) + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_ISSUE,
        S_WAIT,
        S_WB,
        S_DONE
    } state_t;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [RB_W-1:0]       rb_q, rb_d;
    logic [CB_W-1:0]       cb_q, cb_d;
    logic [DATA_WIDTH-1:0] y_buf_q [OUT_SIZE];

    logic last_col;
    logic last_row;
    logic issue_last;
    logic wait_expired;
    logic acc_phase;
    logic acc_drive;
    logic buf_clr;
    logic buf_wr;

    assign last_col     = (cb_q == CB_W'(N_COLBLK - 1));
    assign last_row     = (rb_q == RB_W'(N_ROWBLK - 1));
    assign issue_last   = (cnt_q == CNT_W'(TILE_SIZE - 1));
    assign wait_expired = (cnt_q == CNT_W'(WAIT_TIMEOUT - 1));

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            rb_q    <= '0;
            cb_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rb_q    <= rb_d;
            cb_q    <= cb_d;
        end
    end

    // Next-state logic; cnt_q times both the issue burst and the WAIT watchdog
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rb_d    = rb_q;
        cb_d    = cb_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_FETCH;
                    cnt_d   = '0;
                    rb_d    = '0;
                    cb_d    = '0;
                end
            end
            S_FETCH: begin
                if (tile_rdy) begin
                    state_d = S_ISSUE;
                    cnt_d   = '0;
                end
            end
            S_ISSUE: begin
                if (issue_last) begin
                    state_d = S_WAIT;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_WAIT: begin
                if (arr_done_tile) begin
                    state_d = S_WB;
                    cnt_d   = '0;
                end else if (wait_expired) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_WB: begin
                if (last_col) begin
                    cb_d = '0;
                    if (last_row) begin
                        rb_d    = '0;
                        state_d = S_DONE;
                    end else begin
                        rb_d    = rb_q + RB_W'(1);
                        state_d = S_FETCH;
                    end
                end else begin
                    cb_d    = cb_q + CB_W'(1);
                    state_d = S_FETCH;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Output decode
    always_comb begin
        busy         = 1'b0;
        done         = 1'b0;
        err          = 1'b0;
        tile_req     = 1'b0;
        arr_valid_in = 1'b0;
        acc_phase    = 1'b0;
        buf_clr      = 1'b0;
        buf_wr       = 1'b0;
        case (state_q)
            S_IDLE: begin
                buf_clr = start;
            end
            S_FETCH: begin
                busy      = 1'b1;
                tile_req  = 1'b1;
                acc_phase = 1'b1;
            end
            S_ISSUE: begin
                busy         = 1'b1;
                arr_valid_in = 1'b1;
                acc_phase    = 1'b1;
            end
            S_WAIT: begin
                busy      = 1'b1;
                acc_phase = 1'b1;
                err       = !arr_done_tile && wait_expired;
            end
            S_WB: begin
                busy   = 1'b1;
                buf_wr = 1'b1;
            end
            S_DONE: begin
                done = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
        acc_drive         = acc_phase && (cb_q != '0);
        arr_accumulate_en = acc_drive;
    end

    // Partial-sum buffer; rows beyond OUT_SIZE in the last row block never match an entry
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int e = 0; e < OUT_SIZE; e++) begin
                y_buf_q[e] <= '0;
            end
        end else if (buf_clr) begin
            for (int e = 0; e < OUT_SIZE; e++) begin
                y_buf_q[e] <= '0;
            end
        end else if (buf_wr) begin
            for (int e = 0; e < OUT_SIZE; e++) begin
                if ((e / TILE_SIZE) == int'(rb_q)) begin
                    y_buf_q[e] <= arr_result_vec[(e % TILE_SIZE)*DATA_WIDTH +: DATA_WIDTH];
                end
            end
        end
    end

    function automatic logic [ADDR_W-1:0] row_addr(input int blk, input int lane);
        int r;
        r = blk * TILE_SIZE + lane;
        return (r < OUT_SIZE) ? ADDR_W'(r) : '0;
    endfunction

    // Feedback lanes: Q8.8 buffer entry widened to the array's Q16.16 accumulator format
    for (genvar gi = 0; gi < TILE_SIZE; gi++) begin : g_lane
        logic [DATA_WIDTH-1:0]        lane_src;
        logic signed [ACC_WIDTH-1:0]  lane_ext;

        always_comb begin
            lane_src = '0;
            for (int b = 0; b < N_ROWBLK; b++) begin
                if ((b * TILE_SIZE + gi < OUT_SIZE) && (int'(rb_q) == b)) begin
                    lane_src = y_buf_q[row_addr(b, gi)];
                end
            end
            lane_ext = ACC_WIDTH'($signed(lane_src));
        end

        assign arr_acc_in_vec[gi*ACC_WIDTH +: ACC_WIDTH] =
            acc_drive ? ACC_WIDTH'(lane_ext <<< FRAC_BITS) : '0;
    end

    assign y_rd_data = (int'(y_rd_addr) < OUT_SIZE) ? y_buf_q[y_rd_addr] : '0;
    assign arr_mode  = 3'b000;
    assign rb_idx    = rb_q;
    assign cb_idx    = cb_q;

endmodule
